// File: rtl/conv_pool_pkg.sv
// conv_pool_pkg: shared FSM type, window timing constant and signed max helper for the pooling stage
package conv_pool_pkg;
  typedef enum logic [2:0] {IDLE, READ, DRAIN, WRITE, FINISH} state_t;
  localparam int WINDOW_CYCLES = 6;
  localparam int POOL_DATA_WIDTH = 16;
  function automatic logic signed [POOL_DATA_WIDTH-1:0] smax(
    input logic signed [POOL_DATA_WIDTH-1:0] a,
    input logic signed [POOL_DATA_WIDTH-1:0] b
  );
    return (b > a) ? b : a;
  endfunction
endpackage

// File: rtl/pool_addr_gen.sv
// pool_addr_gen: channel/row/column/tap counters producing pooling read addresses and the output index
module pool_addr_gen #(
  parameter int ADDR_WIDTH = 10,
  parameter int CONV_RESULT_WIDTH = 10,
  parameter int CONV_RESULT_HEIGHT = 10,
  parameter int CHANNEL_NUM = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  step,
  input  logic                  advance,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [2:0]            rd_select,
  output logic [ADDR_WIDTH-1:0] out_cnt,
  output logic                  last_k,
  output logic                  last_win
);
  localparam int OUT_W = CONV_RESULT_WIDTH / 2;
  localparam int OUT_H = CONV_RESULT_HEIGHT / 2;
  localparam logic [ADDR_WIDTH-1:0] PC_LAST = ADDR_WIDTH'(OUT_W - 1);
  localparam logic [ADDR_WIDTH-1:0] PR_LAST = ADDR_WIDTH'(OUT_H - 1);
  localparam logic [2:0] CH_LAST = 3'(CHANNEL_NUM - 1);
  localparam logic [ADDR_WIDTH-1:0] ROW = ADDR_WIDTH'(CONV_RESULT_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] ONE = ADDR_WIDTH'(1);
  logic [ADDR_WIDTH-1:0] pc, pr;
  logic [2:0] ch;
  logic [1:0] k;
  logic pc_end, pr_end, ch_end;
  assign pc_end = pc == PC_LAST;
  assign pr_end = pr == PR_LAST;
  assign ch_end = ch == CH_LAST;
  assign last_k = k == 2'd3;
  assign last_win = pc_end && pr_end && ch_end;
  assign rd_select = ch;
  assign rd_addr = (pr << 1) * ROW + (pc << 1) + (k[1] ? ROW : '0) + ADDR_WIDTH'(k[0]);
  always_ff @(posedge clk)
    if (reset || clear) begin
      pc <= '0;
      pr <= '0;
      ch <= '0;
      k <= '0;
      out_cnt <= '0;
    end else begin
      if (step) k <= k + 2'd1;
      if (advance) begin
        out_cnt <= last_win ? '0 : out_cnt + ONE;
        pc <= pc_end ? '0 : pc + ONE;
        if (pc_end) pr <= pr_end ? '0 : pr + ONE;
        if (pc_end && pr_end) ch <= ch_end ? '0 : ch + 3'd1;
      end
    end
endmodule

// File: rtl/conv2_pool_stage.sv
// conv2_pool_stage: 2x2 stride-2 signed max-pool of conv-2 results into an output memory; CONV2_POOL_RELU_EN adds ReLU
module conv2_pool_stage
  import conv_pool_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int FRACTION_WIDTH = 8,
  parameter int ADDR_WIDTH = 10,
  parameter int CONV_RESULT_WIDTH = 10,
  parameter int CONV_RESULT_HEIGHT = 10,
  parameter int CHANNEL_NUM = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [2:0]            rd_select,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  busy,
  output logic                  done
);
  state_t state, state_nx;
  logic vld, first, last_k, last_win;
  logic [ADDR_WIDTH-1:0] out_cnt;
  logic signed [DATA_WIDTH-1:0] rd_val, max_reg, pooled;
  pool_addr_gen #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .CONV_RESULT_WIDTH(CONV_RESULT_WIDTH),
    .CONV_RESULT_HEIGHT(CONV_RESULT_HEIGHT),
    .CHANNEL_NUM(CHANNEL_NUM)
  ) u_gen (
    .clk(clk),
    .reset(reset),
    .clear(state == IDLE && start),
    .step(state == READ),
    .advance(state == WRITE),
    .rd_addr(rd_addr),
    .rd_select(rd_select),
    .out_cnt(out_cnt),
    .last_k(last_k),
    .last_win(last_win)
  );
  always_ff @(posedge clk) state <= reset ? IDLE : state_nx;
  always_comb begin
    state_nx = state;
    state_nx = state == IDLE  ? (start ? READ : IDLE) :
               state == READ  ? (last_k ? DRAIN : READ) :
               state == DRAIN ? WRITE :
               state == WRITE ? (last_win ? FINISH : READ) : IDLE;
  end
  assign rd_val = rd_data;
  always_ff @(posedge clk)
    if (reset) begin
      vld <= 1'b0;
      first <= 1'b0;
      max_reg <= '0;
    end else begin
      vld <= state == READ;
      first <= state == READ && !vld;
      max_reg <= !vld ? max_reg : first ? rd_val : smax(max_reg, rd_val);
    end
`ifdef CONV2_POOL_RELU_EN
  assign pooled = max_reg[DATA_WIDTH-1] ? '0 : max_reg;
`else
  assign pooled = max_reg;
`endif
  assign wr_en = state == WRITE;
  assign wr_addr = wr_en ? out_cnt : '0;
  assign wr_data = wr_en ? {pooled[DATA_WIDTH-1:FRACTION_WIDTH], pooled[FRACTION_WIDTH-1:0]} : '0;
  assign busy = state == READ || state == DRAIN || state == WRITE;
  assign done = state == FINISH;
endmodule

// File: tb/tb_conv2_pool_stage.sv
// tb_conv2_pool_stage: directed checks of the pooling stage on 4x4x2 and 5x5x1 geometries
module tb_conv2_pool_stage;
  logic clk = 1'b0, reset = 1'b1, start_a = 1'b0, start_b = 1'b0;
  always #5 clk = ~clk;
  logic [9:0] rd_addr_a, wr_addr_a, rd_addr_b, wr_addr_b;
  logic [2:0] rd_select_a, rd_select_b;
  logic [15:0] rd_data_a, wr_data_a, rd_data_b, wr_data_b;
  logic wr_en_a, busy_a, done_a, wr_en_b, busy_b, done_b;
  logic [15:0] mem_a [2][16];
  logic [15:0] mem_b [32];
  int total = 0, bad = 0;
  int exp_r [8] = '{5, 7, 13, 15, 21, 23, 29, 31};
  int exp_b [4] = '{6, 8, 16, 18};
  conv2_pool_stage #(.CONV_RESULT_WIDTH(4), .CONV_RESULT_HEIGHT(4), .CHANNEL_NUM(2)) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .rd_addr(rd_addr_a), .rd_select(rd_select_a),
    .rd_data(rd_data_a), .wr_en(wr_en_a), .wr_addr(wr_addr_a), .wr_data(wr_data_a),
    .busy(busy_a), .done(done_a)
  );
  conv2_pool_stage #(.CONV_RESULT_WIDTH(5), .CONV_RESULT_HEIGHT(5), .CHANNEL_NUM(1)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .rd_addr(rd_addr_b), .rd_select(rd_select_b),
    .rd_data(rd_data_b), .wr_en(wr_en_b), .wr_addr(wr_addr_b), .wr_data(wr_data_b),
    .busy(busy_b), .done(done_b)
  );
  always @(posedge clk) rd_data_a <= mem_a[rd_select_a[0]][rd_addr_a[3:0]];
  always @(posedge clk) rd_data_b <= mem_b[rd_addr_b[4:0]];
  int rel_a = 1000, rel_b = 1000, nw_a = 0, nw_b = 0, nd_a = 0, nd_b = 0;
  int done_rel_a = 0, done_rel_b = 0, addr_bad_b = 0;
  logic [9:0] wa_a [64];
  logic [15:0] wd_a [64];
  logic [9:0] wa_b [16];
  logic [15:0] wd_b [16];
  logic [9:0] tr_addr [64];
  logic [2:0] tr_sel [64];
  always @(negedge clk) begin
    if (start_a && !busy_a && !done_a) rel_a <= 1;
    else if (rel_a < 1000) rel_a <= rel_a + 1;
    if (rel_a < 64) begin
      tr_addr[rel_a] <= rd_addr_a;
      tr_sel[rel_a] <= rd_select_a;
    end
    if (wr_en_a) begin
      if (nw_a < 64) begin
        wa_a[nw_a] <= wr_addr_a;
        wd_a[nw_a] <= wr_data_a;
      end
      nw_a <= nw_a + 1;
    end
    if (done_a) begin
      nd_a <= nd_a + 1;
      done_rel_a <= rel_a;
    end
  end
  always @(negedge clk) begin
    if (start_b && !busy_b && !done_b) rel_b <= 1;
    else if (rel_b < 1000) rel_b <= rel_b + 1;
    if (busy_b && (rd_addr_b >= 10'd20 || rd_addr_b % 10'd5 == 10'd4)) addr_bad_b <= addr_bad_b + 1;
    if (wr_en_b) begin
      if (nw_b < 16) begin
        wa_b[nw_b] <= wr_addr_b;
        wd_b[nw_b] <= wr_data_b;
      end
      nw_b <= nw_b + 1;
    end
    if (done_b) begin
      nd_b <= nd_b + 1;
      done_rel_b <= rel_b;
    end
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic pulse_a();
    @(posedge clk);
    #1 start_a = 1'b1;
    @(posedge clk);
    #1 start_a = 1'b0;
  endtask
  task automatic wait_done_a();
    int n = 0;
    int d0 = nd_a;
    while (nd_a == d0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("a_done_timeout", n < 300, 1);
    repeat (3) @(negedge clk);
  endtask
  task automatic check_ramp(input int base);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("ramp_addr%0d", i), wa_a[base + i], i);
      chk($sformatf("ramp_data%0d", i), wd_a[base + i], exp_r[i]);
    end
  endtask
  initial begin
    int b0, d0, n;
    for (int c = 0; c < 2; c++)
      for (int a = 0; a < 16; a++) mem_a[c][a] = 16'(a + 16 * c);
    for (int a = 0; a < 32; a++) mem_b[a] = 16'(a);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_rd_addr", rd_addr_a, 0);
    chk("rst_rd_select", rd_select_a, 0);
    chk("rst_wr_en", wr_en_a, 0);
    chk("rst_wr_addr", wr_addr_a, 0);
    chk("rst_wr_data", wr_data_a, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_done", done_a, 0);
    b0 = nw_a;
    pulse_a();
    wait_done_a();
    chk("ramp_count", nw_a - b0, 8);
    check_ramp(b0);
    chk("ramp_done_cycle", done_rel_a, 49);
    chk("ramp_done_count", nd_a, 1);
    chk("tr_w0_k0", tr_addr[1], 0);
    chk("tr_w0_k1", tr_addr[2], 1);
    chk("tr_w0_k2", tr_addr[3], 4);
    chk("tr_w0_k3", tr_addr[4], 5);
    chk("tr_w1_k0", tr_addr[7], 2);
    chk("tr_w1_k1", tr_addr[8], 3);
    chk("tr_w1_k2", tr_addr[9], 6);
    chk("tr_w1_k3", tr_addr[10], 7);
    chk("tr_sel_drain0", tr_sel[23], 0);
    chk("tr_sel_last_ch0", tr_sel[24], 0);
    chk("tr_sel_first_ch1", tr_sel[25], 1);
    b0 = nw_a;
    d0 = nd_a;
    pulse_a();
    repeat (8) @(posedge clk);
    #1 start_a = 1'b1;
    @(posedge clk);
    #1 start_a = 1'b0;
    wait_done_a();
    repeat (60) @(negedge clk);
    chk("busy_start_count", nw_a - b0, 8);
    chk("busy_start_dones", nd_a - d0, 1);
    chk("busy_start_done_cycle", done_rel_a, 49);
    check_ramp(b0);
    b0 = nw_a;
    d0 = nd_a;
    pulse_a();
    repeat (18) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    chk("mid_rst_rd_addr", rd_addr_a, 0);
    chk("mid_rst_rd_select", rd_select_a, 0);
    chk("mid_rst_wr_en", wr_en_a, 0);
    chk("mid_rst_wr_addr", wr_addr_a, 0);
    chk("mid_rst_wr_data", wr_data_a, 0);
    chk("mid_rst_busy", busy_a, 0);
    chk("mid_rst_done", done_a, 0);
    repeat (30) @(negedge clk);
    chk("mid_rst_writes", nw_a - b0, 3);
    chk("mid_rst_no_done", nd_a - d0, 0);
    b0 = nw_a;
    pulse_a();
    wait_done_a();
    chk("fresh_count", nw_a - b0, 8);
    check_ramp(b0);
    mem_a[0][0] = 16'hFFFD;
    mem_a[0][1] = 16'hFFFF;
    mem_a[0][4] = 16'hFFF8;
    mem_a[0][5] = 16'hFFFE;
    b0 = nw_a;
    pulse_a();
    wait_done_a();
    chk("neg_count", nw_a - b0, 8);
`ifdef CONV2_POOL_RELU_EN
    chk("neg_relu_data", wd_a[b0], 16'h0000);
`else
    chk("neg_data", wd_a[b0], 16'hFFFF);
`endif
    chk("neg_next_data", wd_a[b0 + 1], 7);
    @(posedge clk);
    #1 start_b = 1'b1;
    @(posedge clk);
    #1 start_b = 1'b0;
    n = 0;
    while (nd_b == 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("b_done_timeout", n < 300, 1);
    repeat (5) @(negedge clk);
    chk("odd_count", nw_b, 4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("odd_addr%0d", i), wa_b[i], i);
      chk($sformatf("odd_data%0d", i), wd_b[i], exp_b[i]);
    end
    chk("odd_no_edge_addr", addr_bad_b, 0);
    chk("odd_done_cycle", done_rel_b, 25);
    chk("odd_done_count", nd_b, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/conv2_pool_stage.md
Name: conv2_pool_stage

Overview:
- Downstream stage of the conv-2 wrapper. Starts on the wrapper's done pulse.
- Reads the conv result memory through the wrapper's read-address/read-select/result path.
- Applies 2x2 stride-2 signed max-pooling per channel.
- Writes pooled values sequentially into an output M10K consumed by the next layer.

Parameters:
- DATA_WIDTH, 16, signed fixed-point sample width.
- FRACTION_WIDTH, 8, fractional bits. Carried through only; the max operation ignores it.
- ADDR_WIDTH, 10, width of the read and write addresses.
- CONV_RESULT_WIDTH, 10, conv result columns per channel.
- CONV_RESULT_HEIGHT, 10, conv result rows per channel.
- CHANNEL_NUM, 2, number of conv result channels (read-select values 0..CHANNEL_NUM-1).

Ports:
- clk  in  1  single clock.
- reset  in  1  synchronous, active-high.
- start  in  1  one-cycle pulse; connected to the conv wrapper's done.
- rd_addr  out  ADDR_WIDTH  drives the wrapper's addr_in.
- rd_select  out  3  drives the wrapper's M10K_read_select; equals the current channel.
- rd_data  in  DATA_WIDTH  the wrapper's out_result_test; valid exactly 1 cycle after rd_addr.
- wr_en  out  1  output-memory write strobe.
- wr_addr  out  ADDR_WIDTH  output-memory address.
- wr_data  out  DATA_WIDTH  pooled value.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse after the final write.

Behaviour:
- Reset values: rd_addr=0, rd_select=0, wr_en=0, wr_addr=0, wr_data=0, busy=0, done=0. All counters cleared; FSM returns to IDLE.
- Reset mid-operation aborts immediately. No further writes occur.
- Output geometry: OUT_W = CONV_RESULT_WIDTH/2 and OUT_H = CONV_RESULT_HEIGHT/2, using floor. On odd dimensions the last column/row is dropped.
- FSM states: IDLE, READ, DRAIN, WRITE, FINISH.
- IDLE: start=1 goes to READ with ch=0, pr=0, pc=0, k=0. start is ignored in every other state.
- READ (k=0..3): rd_addr = base + {0, 1, CONV_RESULT_WIDTH, CONV_RESULT_WIDTH+1}[k]. base = (2*pr)*CONV_RESULT_WIDTH + 2*pc. After k=3, go to DRAIN.
- Capture: a one-cycle-delayed valid flag captures rd_data. The first captured sample loads max_reg; each later sample replaces it if larger under signed compare.
- DRAIN: 1 cycle; captures the 4th sample.
- WRITE: 1 cycle. wr_en=1, wr_addr=out_cnt, wr_data=max_reg (after the optional ReLU). Then out_cnt++.
- Scan order is pc first, then pr, then ch. At the last pc/pr/ch go to FINISH, otherwise go to READ with k=0.
- FINISH: done=1 for 1 cycle, busy=0, then IDLE.
- Timing: each window takes exactly 6 cycles (4 READ + DRAIN + WRITE).
- Latency: start accepted at edge N gives the first rd_addr in cycle N+1. done is asserted in cycle N+1+6*CHANNEL_NUM*OUT_H*OUT_W.
- out_cnt runs continuously across channels: out_cnt = ch*OUT_H*OUT_W + pr*OUT_W + pc.
- rd_select is stable for the whole of a channel, including its DRAIN cycle. It changes only on the transition into the next channel's READ.
- Equal samples: the compare is strictly greater, so the earliest sample is kept (no functional difference).
- wr_en is never asserted outside WRITE.

Optional Feature:
- Macro: CONV2_POOL_RELU_EN.
- Defined: wr_data = 0 when max_reg is negative (MSB=1), otherwise max_reg (ReLU after pooling).
- Undefined: wr_data = max_reg unchanged, negatives pass through.
- Timing is identical in both builds.

Decomposition:
- Package conv_pool_pkg holds:
  - the state enum type for IDLE/READ/DRAIN/WRITE/FINISH;
  - the constant WINDOW_CYCLES=6;
  - a signed max function over DATA_WIDTH.
- One sub-module, pool_addr_gen. It owns the ch/pr/pc/k counters and computes rd_addr, rd_select, the last-window flag and out_cnt. The top level holds the FSM, the capture/max datapath and the write port.

Test Plan:
- Ramp, 4x4, 2 channels: CONV_RESULT_WIDTH=HEIGHT=4, CHANNEL_NUM=2, memory[ch][a] = a + 16*ch, one start pulse.
  - Expect 8 writes, wr_addr 0..7, wr_data {5,7,13,15,21,23,29,31}.
  - Expect done exactly 49 cycles after start is sampled.
- Address order: same setup, check rd_addr for window 0 of ch0 is 0,1,4,5 on consecutive cycles. Window 1 is 2,3,6,7. rd_select switches 0→1 at the 25th READ cycle.
- Negatives: all samples in window 0 are {-3,-1,-8,-2} as 16-bit two's complement.
  - Without the macro, wr_data=0xFFFF (-1).
  - With CONV2_POOL_RELU_EN, wr_data=0.
- Odd size: WIDTH=HEIGHT=5, CHANNEL_NUM=1. Expect 4 writes only; row 4 and column 4 are never addressed (no rd_addr ≥20, none with addr%5==4).
- Start while busy: pulse start again at cycle 10. Expect no restart, the write count is unchanged and a single done pulse.
- Reset mid-run: assert reset for 1 cycle at cycle 20.
  - Next cycle: all outputs 0, busy=0, no wr_en.
  - A fresh start then reproduces the ramp results from wr_addr 0.
